// File: rtl/min_max_job_scheduler.sv
// Two-requester job scheduler: copies a 16-byte array into a min/max finder,
// runs it with a timeout and returns max/min/cycle count to the job owner.
module min_max_job_scheduler #(
  parameter logic [7:0] TIMEOUT = 8'd200
) (
  input  logic         Clk,
  input  logic         Resetb,
  input  logic         Req0,
  input  logic         Req1,
  input  logic [127:0] Data0,
  input  logic [127:0] Data1,
  output logic         Ack0,
  output logic         Ack1,
  output logic         Rdy,
  output logic         Owner,
  output logic [7:0]   Max_out,
  output logic [7:0]   Min_out,
  output logic [7:0]   Cycles,
  output logic         Err,
  output logic         Fnd_Wr_En,
  output logic [3:0]   Fnd_Wr_Addr,
  output logic [7:0]   Fnd_Wr_Data,
  output logic         Fnd_Start,
  output logic         Fnd_Ack,
  input  logic         Fnd_Qi,
  input  logic         Fnd_Qd,
  input  logic [7:0]   Fnd_Max,
  input  logic [7:0]   Fnd_Min
);

  typedef enum logic [2:0] {
    S_IDLE, S_GRANT, S_WRITE, S_START, S_WAIT, S_RESULT
  } state_t;

  state_t       r_state;
  logic         r_last;
  logic         r_gnt;
  logic [127:0] r_buf;
  logic [3:0]   r_addr;
  logic [7:0]   r_cnt;
  logic         r_owner;
  logic [7:0]   r_max;
  logic [7:0]   r_min;
  logic [7:0]   r_cycles;
  logic         r_err;

  logic         w_pick;
  logic [7:0]   w_cnt_nxt;

  // On a tie the requester that was not served last wins
  assign w_pick    = (Req0 & Req1) ? ~r_last : Req1;
  assign w_cnt_nxt = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;

  assign Ack0        = (r_state == S_GRANT) & ~r_gnt;
  assign Ack1        = (r_state == S_GRANT) &  r_gnt;
  assign Rdy         = (r_state == S_RESULT);
  assign Fnd_Ack     = (r_state == S_RESULT);
  assign Fnd_Wr_En   = (r_state == S_WRITE);
  assign Fnd_Wr_Addr = r_addr;
  assign Fnd_Wr_Data = r_buf[{r_addr, 3'b000} +: 8];
  assign Fnd_Start   = (r_state == S_START) & Fnd_Qi;
  assign Owner       = r_owner;
  assign Max_out     = r_max;
  assign Min_out     = r_min;
  assign Cycles      = r_cycles;
  assign Err         = r_err;

  always_ff @(posedge Clk or negedge Resetb) begin
    if (!Resetb) begin
      r_state  <= S_IDLE;
      r_last   <= 1'b1;
      r_gnt    <= 1'b0;
      r_buf    <= '0;
      r_addr   <= '0;
      r_cnt    <= '0;
      r_owner  <= 1'b0;
      r_max    <= '0;
      r_min    <= '0;
      r_cycles <= '0;
      r_err    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (Req0 | Req1) begin
            r_gnt   <= w_pick;
            r_buf   <= w_pick ? Data1 : Data0;
            r_state <= S_GRANT;
          end
        end
        S_GRANT: begin
          r_addr  <= '0;
          r_state <= S_WRITE;
        end
        S_WRITE: begin
          r_addr <= r_addr + 4'd1;
          if (r_addr == 4'd15)
            r_state <= S_START;
        end
        S_START: begin
          if (Fnd_Qi) begin
            r_cnt   <= '0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (Fnd_Qd) begin
            r_max    <= Fnd_Max;
            r_min    <= Fnd_Min;
            r_cycles <= r_cnt;
            r_err    <= 1'b0;
            r_owner  <= r_gnt;
            r_state  <= S_RESULT;
          end else if (w_cnt_nxt == TIMEOUT) begin
            // Abort: neutral result so a consumer ignoring Err sees no range
            r_max    <= 8'h00;
            r_min    <= 8'hFF;
            r_cycles <= TIMEOUT;
            r_err    <= 1'b1;
            r_owner  <= r_gnt;
            r_state  <= S_RESULT;
          end else begin
            r_cnt <= w_cnt_nxt;
          end
        end
        S_RESULT: begin
          r_last  <= r_gnt;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_min_max_job_scheduler.sv
// Directed bench for min_max_job_scheduler with a behavioural finder
// and a result scoreboard.
module tb_min_max_job_scheduler;

  localparam logic [7:0] TIMEOUT = 8'd200;

  logic         Clk;
  logic         Resetb;
  logic         Req0, Req1;
  logic [127:0] Data0, Data1;
  logic         Ack0, Ack1, Rdy, Owner, Err;
  logic [7:0]   Max_out, Min_out, Cycles;
  logic         Fnd_Wr_En, Fnd_Start, Fnd_Ack;
  logic [3:0]   Fnd_Wr_Addr;
  logic [7:0]   Fnd_Wr_Data;
  logic         Fnd_Qi, Fnd_Qd;
  logic [7:0]   Fnd_Max, Fnd_Min;

  min_max_job_scheduler #(.TIMEOUT(TIMEOUT)) dut (
    .Clk(Clk), .Resetb(Resetb),
    .Req0(Req0), .Req1(Req1), .Data0(Data0), .Data1(Data1),
    .Ack0(Ack0), .Ack1(Ack1), .Rdy(Rdy), .Owner(Owner),
    .Max_out(Max_out), .Min_out(Min_out), .Cycles(Cycles), .Err(Err),
    .Fnd_Wr_En(Fnd_Wr_En), .Fnd_Wr_Addr(Fnd_Wr_Addr),
    .Fnd_Wr_Data(Fnd_Wr_Data), .Fnd_Start(Fnd_Start), .Fnd_Ack(Fnd_Ack),
    .Fnd_Qi(Fnd_Qi), .Fnd_Qd(Fnd_Qd), .Fnd_Max(Fnd_Max), .Fnd_Min(Fnd_Min)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Behavioural finder: INI(0) -> RUN(1) for run_len cycles -> DONE(2)
  int         run_len;
  bit         qi_en;
  int         fst;
  int         rcnt;
  logic [7:0] fm [16];
  logic [7:0] fmx, fmn;

  always @(posedge Clk)
    if (Fnd_Wr_En) fm[Fnd_Wr_Addr] <= Fnd_Wr_Data;

  always_comb begin
    fmx = fm[0];
    fmn = fm[0];
    for (int i = 1; i < 16; i++) begin
      if (fm[i] > fmx) fmx = fm[i];
      if (fm[i] < fmn) fmn = fm[i];
    end
  end

  always @(posedge Clk or negedge Resetb) begin
    if (!Resetb) begin
      fst     <= 0;
      rcnt    <= 0;
      Fnd_Max <= 8'h00;
      Fnd_Min <= 8'h00;
    end else begin
      case (fst)
        0: if (Fnd_Start) begin fst <= 1; rcnt <= run_len; end
        1: begin
          if (Fnd_Ack) fst <= 0;
          else if (rcnt <= 1) begin
            fst <= 2; Fnd_Max <= fmx; Fnd_Min <= fmn;
          end else rcnt <= rcnt - 1;
        end
        default: if (Fnd_Ack) fst <= 0;
      endcase
    end
  end

  assign Fnd_Qi = (fst == 0) && qi_en;
  assign Fnd_Qd = (fst == 2);

  typedef struct {
    logic       owner;
    logic [7:0] mx;
    logic [7:0] mn;
    logic       err;
    logic [7:0] cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [25:0] prev_v;

  localparam logic [127:0] D0 = 128'hF5_84_02_02_99_02_85_F4_F4_23_83_90_F4_64_9A_3B;
  localparam logic [127:0] D1 = 128'h01_B9_40_55_66_77_12_34_56_78_9A_A0_B0_0A_20_93;
  localparam logic [127:0] D2 = 128'h10_20_30_40_50_60_70_80_90_A0_B0_C0_D0_E0_F0_FF;
  localparam logic [127:0] D3 = 128'h7F_7F_7F_7F_7F_7F_7F_7F_7F_7F_7F_7F_7F_7F_7F_7F;
  localparam logic [127:0] D4 = 128'h00_11_22_33_44_55_66_77_88_99_AA_BB_CC_DD_EE_80;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic mm(input logic [127:0] d, output logic [7:0] mx,
                    output logic [7:0] mn);
    mx = d[7:0];
    mn = d[7:0];
    for (int i = 1; i < 16; i++) begin
      if (d[8*i +: 8] > mx) mx = d[8*i +: 8];
      if (d[8*i +: 8] < mn) mn = d[8*i +: 8];
    end
  endtask

  function automatic logic [43:0] outs();
    return {Ack0, Ack1, Rdy, Owner, Max_out, Min_out, Cycles, Err,
            Fnd_Wr_En, Fnd_Wr_Addr, Fnd_Wr_Data, Fnd_Start, Fnd_Ack};
  endfunction

  task automatic run_job(input bit r0, input bit r1,
                         input logic [127:0] d0, input logic [127:0] d1,
                         input bit own, input int run, input int qd);
    exp_t         e;
    logic [127:0] d;
    int           k, kexp;
    d = own ? d1 : d0;
    e.owner = own;
    if (run >= int'(TIMEOUT)) begin
      e.mx = 8'h00; e.mn = 8'hFF; e.err = 1'b1; e.cyc = TIMEOUT;
      kexp = int'(TIMEOUT) + 1;
    end else begin
      mm(d, e.mx, e.mn); e.err = 1'b0; e.cyc = 8'(run);
      kexp = run + 2;
    end
    @(negedge Clk);
    run_len = run;
    qi_en = (qd == 0);
    Req0 = r0; Req1 = r1; Data0 = d0; Data1 = d1;
    sb.push_back(e);
    @(negedge Clk);
    chk("ack", 128'({Ack0, Ack1}), 128'({!own, own}));
    chk("hold", 128'({Owner, Max_out, Min_out, Cycles, Err}), 128'(prev_v));
    if (own) Req1 = 1'b0; else Req0 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge Clk);
      chk("wr", 128'({Fnd_Wr_En, Fnd_Wr_Addr, Fnd_Wr_Data}),
          128'({1'b1, 4'(i), d[8*i +: 8]}));
    end
    @(negedge Clk);
    for (int j = 0; j < qd; j++) begin
      chk("start_lo", 128'(Fnd_Start), 128'(0));
      @(negedge Clk);
    end
    qi_en = 1'b1;
    #1;
    chk("start", 128'(Fnd_Start), 128'(1));
    k = 0;
    while (!Rdy && k < kexp + 5) begin
      @(negedge Clk);
      k++;
      if (k == 1) chk("start_w", 128'(Fnd_Start), 128'(0));
    end
    chk("rdy_lat", 128'(k), 128'(kexp));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("result", 128'({Rdy, Fnd_Ack, Owner, Max_out, Min_out, Err, Cycles}),
          128'({2'b11, e.owner, e.mx, e.mn, e.err, e.cyc}));
      prev_v = {e.owner, e.mx, e.mn, e.cyc, e.err};
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    Resetb = 1'b0; Req0 = 1'b0; Req1 = 1'b0;
    Data0 = '0; Data1 = '0;
    run_len = 1; qi_en = 1'b1; prev_v = '0;
    #12;
    chk("rst_in", 128'(outs()), 128'(0));
    @(negedge Clk); @(negedge Clk);
    Resetb = 1'b1;
    @(negedge Clk);
    chk("rst_out", 128'(outs()), 128'(0));

    run_job(1'b1, 1'b1, D0, D1, 1'b0, 3, 0);
    run_job(1'b1, 1'b1, D0, D1, 1'b1, 5, 0);
    run_job(1'b1, 1'b1, D2, D1, 1'b0, 1, 0);
    run_job(1'b1, 1'b1, D2, D3, 1'b1, 7, 0);
    run_job(1'b1, 1'b0, D0, D3, 1'b0, 4, 5);
    run_job(1'b0, 1'b1, D0, D4, 1'b1, 1000, 0);
    run_job(1'b1, 1'b0, D4, D0, 1'b0, 199, 0);
    run_job(1'b0, 1'b1, D0, D4, 1'b1, 200, 0);

    @(negedge Clk);
    Req0 = 1'b1; Req1 = 1'b0; Data0 = D2;
    @(negedge Clk);
    chk("mid_ack", 128'({Ack0, Ack1}), 128'(2'b10));
    Req0 = 1'b0;
    k = 0;
    while (!(Fnd_Wr_En && Fnd_Wr_Addr == 4'd7) && k < 20) begin
      @(negedge Clk);
      k++;
    end
    chk("addr7", 128'({Fnd_Wr_En, Fnd_Wr_Addr}), 128'({1'b1, 4'd7}));
    Resetb = 1'b0;
    #1;
    chk("rst_mid", 128'(outs()), 128'(0));
    @(negedge Clk);
    Resetb = 1'b1;
    prev_v = '0;
    k = 0;
    repeat (30) begin
      @(negedge Clk);
      if (Rdy | Ack0 | Ack1) k++;
    end
    chk("no_rdy", 128'(k), 128'(0));
    run_job(1'b0, 1'b1, D0, D3, 1'b1, 2, 0);

    chk("sb_empty", 128'(sb.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
